multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences the shared single-ALU, single-memory RV32I multicycle datapath.
- Decodes the opcode, walks each instruction through fetch/decode/execute/memory/writeback steps and drives every datapath enable and mux select.
- Stalls on a memory ready handshake, counts instruction retirement, and halts on illegal opcodes or memory timeout.
- Sits between the instruction register/ALU flags and the datapath's PC, IR, register-file and memory-port enables.

Parameters:
TIMEOUT_CYCLES, 255, consecutive cycles a memory access may wait for mem_ready before bus error (must be >= 1)
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of internal wait counter (derived, do not override)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  opcode from instruction register
funct3  input  3  instr[14:12]
funct7_5  input  1  instr[30]
Zero  input  1  ALU zero flag (current cycle)
mem_ready  input  1  memory access completes this cycle
PCWrite  output  1  PC register load
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write strobe
IRWrite  output  1  IR/OldPC load
ResultSrc  output  2  result mux: 00 ALUOut, 01 ReadData, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 reg A
ALUSrcB  output  2  00 rs2 reg B, 01 ImmExt, 10 constant 4
ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
RegWrite  output  1  register file write
instr_done  output  1  one-cycle pulse on last cycle of each retired instruction
illegal  output  1  one-cycle pulse on unsupported opcode
bus_err  output  1  one-cycle pulse on memory timeout
halted  output  1  high while in HALT

Behaviour:
- Reset:
  - rst_n low forces state FETCH and wait counter 0.
  - While rst_n is low, all outputs are 0, including mux selects; ALUControl is ADD.
  - Reset mid-instruction aborts it; no partial write is issued.
- Unlisted outputs are 0 and ALUControl is ADD in every state.
- ImmSrc is decoded combinationally from op in all states:
  - lw, I-ALU (0010011), jalr: 00
  - sw: 01
  - branch: 10
  - jal: 11
  - otherwise 00
- States and transitions:
  - FETCH:
    - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10.
    - IRWrite=PCWrite=mem_ready.
    - Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE:
    - ALUSrcA=01, ALUSrcB=01, ADD (latches the branch/jal target in ALUOut).
    - Next state by op: 0000011/0100011 MEMADR; 0110011 EXECR; 0010011 EXECI; 1100011 BRANCH; 1101111 JAL; 1100111 JALR.
    - Any other op: pulse illegal, go to HALT.
  - MEMADR:
    - ALUSrcA=10, ALUSrcB=01, ADD.
    - Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00; waits for mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done; goes to FETCH.
  - MEMWRITE:
    - AdrSrc=1, ResultSrc=00, MemWrite=1 held for every cycle until mem_ready.
    - On mem_ready: instr_done, go to FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALU op per decode rule below; goes to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALU op per decode rule below; goes to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done; goes to FETCH.
  - BRANCH:
    - ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00.
    - PCWrite = (funct3==000 & Zero) | (funct3==001 & ~Zero); other funct3 values are never taken.
    - instr_done; goes to FETCH.
  - JAL: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ADD; goes to ALUWB.
  - JALR: ALUSrcA=10, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1; goes to LINK. Clearing target bit 0 is the datapath's job.
  - LINK: ALUSrcA=01, ALUSrcB=10, ADD; goes to ALUWB.
  - HALT: all enables 0, halted=1; sticky until rst_n.
- ALU decode rule (EXECR/EXECI):
  - funct3 000: SUB if op==0110011 & funct7_5, else ADD.
  - funct3 010: SLT.
  - funct3 110: OR.
  - funct3 111: AND.
  - Other funct3: ADD, no flag.
- Memory timeout (FETCH, MEMREAD, MEMWRITE):
  - Counter increments each cycle the state waits without mem_ready.
  - Counter clears on mem_ready or on state change.
  - When the counter reaches TIMEOUT_CYCLES: pulse bus_err, go to HALT, and deassert MemWrite/IRWrite/PCWrite that cycle.
  - mem_ready on the same cycle as the limit wins: normal completion, no error.
- Cycle counts with mem_ready held high:
  - lw: 5.
  - sw, R/I-ALU, jal: 4.
  - branch: 3.
  - jalr: 5.

Test Plan:
- Reset release with mem_ready=1, IR add x3,x1,x2 (op 0110011, f3 000, f7_5 0) -> states FETCH, DECODE, EXECR (ALUControl 000), ALUWB (RegWrite=1, instr_done=1); 4 cycles.
- sub variant (f7_5=1) -> ALUControl 001 in EXECR; addi with f7_5=1 -> ALUControl 000.
- lw with mem_ready low 3 cycles in MEMREAD -> AdrSrc=1 held 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1; sw with 2 wait cycles -> MemWrite=1 for exactly 3 cycles.
- beq Zero=1 -> PCWrite=1 in BRANCH; bne Zero=1 -> PCWrite=0; funct3 100 -> PCWrite=0; all give instr_done.
- op 0000000 -> illegal pulse in DECODE, halted=1 thereafter with mem_ready toggling; rst_n low -> FETCH, halted=0.
- TIMEOUT_CYCLES=4, mem_ready stuck low in FETCH -> bus_err on 5th cycle, HALT; repeat with mem_ready rising on that cycle -> no bus_err, DECODE; async rst_n pulse in MEMWRITE -> MemWrite drops immediately.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared-ALU, shared-memory RV32I multicycle datapath.
// Drives every datapath enable and mux select, stalls on mem_ready, halts on illegal op or bus timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic       halted
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_LINK     = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [3:0]       state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_state, timeout_hit;
  logic [2:0]       alu_op;

  assign wait_state  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout_hit = wait_state && !mem_ready && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    unique case (funct3)
      3'b000:  alu_op = (op == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      // Every exit from a wait state is via mem_ready or timeout, so this also clears on state change.
      wait_cnt <= (wait_state && !mem_ready && !timeout_hit) ? wait_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
                  else if (timeout_hit) next_state = S_HALT;
      S_DECODE: begin
        unique case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BR:        next_state = S_BRANCH;
          OP_JAL:       next_state = S_JAL;
          OP_JALR:      next_state = S_JALR;
          default:      next_state = S_HALT;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
                  else if (timeout_hit) next_state = S_HALT;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
                  else if (timeout_hit) next_state = S_HALT;
      S_EXECR, S_EXECI, S_JAL, S_LINK: next_state = (state == S_JAL || state == S_LINK ||
                                                     state == S_EXECR || state == S_EXECI)
                                                    ? S_ALUWB : state;
      S_MEMWB, S_ALUWB, S_BRANCH:      next_state = S_FETCH;
      S_JALR:     next_state = S_LINK;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = 2'b00;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    halted     = 1'b0;
    // Outputs are forced low combinationally while reset is held, not just after the next edge.
    if (rst_n) begin
      unique case (op)
        OP_SW:   ImmSrc = 2'b01;
        OP_BR:   ImmSrc = 2'b10;
        OP_JAL:  ImmSrc = 2'b11;
        default: ImmSrc = 2'b00;
      endcase
      bus_err = timeout_hit;
      unique case (state)
        S_FETCH: begin
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          illegal = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR});
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD:  AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc  = 2'b01;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc     = 1'b1;
          MemWrite   = !timeout_hit;
          instr_done = mem_ready;
        end
        S_EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = alu_op;
        end
        S_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = alu_op;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = ALU_SUB;
          PCWrite    = (funct3 == 3'b000 && Zero) || (funct3 == 3'b001 && !Zero);
          instr_done = 1'b1;
        end
        S_JAL: begin
          PCWrite = 1'b1;
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_JALR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        S_LINK: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle output list from the instruction-level timing rules and compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  typedef struct packed {
    logic       halt, berr, ill, done, rw;
    logic [1:0] imm;
    logic [2:0] alu;
    logic [1:0] sb, sa, rs;
    logic       irw, mw, adr, pcw;
  } outs_t;

  typedef struct {
    logic  mr;
    outs_t o;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, Zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_done, illegal, bus_err, halted;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_done(instr_done),
    .illegal(illegal), .bus_err(bus_err), .halted(halted)
  );

  always #5 clk = ~clk;

  outs_t obs;
  assign obs = {halted, bus_err, illegal, instr_done, RegWrite, ImmSrc, ALUControl,
                ALUSrcB, ALUSrcA, ResultSrc, IRWrite, MemWrite, AdrSrc, PCWrite};

  int    total = 0;
  int    bad   = 0;
  step_t q[$];
  bit    ends_halted;

  task automatic check(input string tag, input outs_t got, input outs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BR) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input logic mr, input outs_t o);
    step_t s;
    s.mr = mr;
    s.o  = o;
    q.push_back(s);
  endtask

  // A memory phase waits w cycles without ready; the (TO+1)th waiting cycle is the bus error.
  task automatic mem_phase(input int w, input outs_t wo, input outs_t dn, output bit timed_out);
    outs_t e;
    timed_out = 1'b0;
    for (int i = 0; i < w; i++) begin
      if (i == TO) begin
        e = wo;
        e.berr = 1'b1; e.mw = 1'b0; e.pcw = 1'b0; e.irw = 1'b0;
        push(1'b0, e);
        timed_out = 1'b1;
        return;
      end
      push(1'b0, wo);
    end
    push(1'b1, dn);
  endtask

  task automatic halt_tail(input outs_t hl);
    for (int i = 0; i < 3; i++) push(rb(), hl);
    ends_halted = 1'b1;
  endtask

  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                       input int wf, input int wm);
    outs_t b, e, d, hl;
    bit    tmo;
    q.delete();
    ends_halted = 1'b0;
    b = '0;
    b.imm = imm_of(o);
    hl = b;
    hl.halt = 1'b1;
    e = b; e.sb = 2'b10; e.rs = 2'b10;
    d = e; d.pcw = 1'b1; d.irw = 1'b1;
    mem_phase(wf, e, d, tmo);
    if (tmo) begin halt_tail(hl); return; end
    e = b; e.sa = 2'b01; e.sb = 2'b01;
    if (!(o inside {LW, SW, RT, IT, BR, JAL, JALR})) begin
      e.ill = 1'b1;
      push(rb(), e);
      halt_tail(hl);
      return;
    end
    push(rb(), e);
    e = b;
    case (o)
      LW, SW: begin
        e.sa = 2'b10; e.sb = 2'b01;
        push(rb(), e);
        e = b; e.adr = 1'b1;
        if (o == SW) e.mw = 1'b1;
        d = e;
        if (o == SW) d.done = 1'b1;
        mem_phase(wm, e, d, tmo);
        if (tmo) begin halt_tail(hl); return; end
        if (o == LW) begin
          e = b; e.rs = 2'b01; e.rw = 1'b1; e.done = 1'b1;
          push(rb(), e);
        end
        return;
      end
      RT, IT: begin
        e.sa = 2'b10; e.sb = (o == IT) ? 2'b01 : 2'b00; e.alu = alu_of(o, f3, f7);
        push(rb(), e);
      end
      BR: begin
        e.sa = 2'b10; e.alu = 3'b001; e.done = 1'b1;
        e.pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
        push(rb(), e);
        return;
      end
      JAL: begin
        e.pcw = 1'b1; e.sa = 2'b01; e.sb = 2'b10;
        push(rb(), e);
      end
      default: begin
        e.sa = 2'b10; e.sb = 2'b01; e.rs = 2'b10; e.pcw = 1'b1;
        push(rb(), e);
        e = b; e.sa = 2'b01; e.sb = 2'b10;
        push(rb(), e);
      end
    endcase
    e = b; e.rw = 1'b1; e.done = 1'b1;
    push(rb(), e);
  endtask

  // Entered and left at posedge+1; outputs sampled at the negedge.
  task automatic run(input int n, input string tag);
    for (int i = 0; i < n && i < q.size(); i++) begin
      mem_ready = q[i].mr;
      @(negedge clk);
      check(tag, obs, q[i].o);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    op = 7'($urandom);
    mem_ready = rb();
    #1 check("reset", obs, '0);
    @(posedge clk);
    @(posedge clk);
    #1 check("reset_hold", obs, '0);
    rst_n = 1'b1;
  endtask

  task automatic instr(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int wf, input int wm);
    op = o; funct3 = f3; funct7_5 = f7; Zero = z;
    build(o, f3, f7, z, wf, wm);
    run(q.size(), tag);
    if (ends_halted) do_reset();
  endtask

  function automatic int pick_wait();
    int r = int'($urandom_range(0, 15));
    return (r == 0) ? TO + 1 : r % (TO + 1);
  endfunction

  logic [6:0] ill_ops [4] = '{7'b0000000, 7'b0110111, 7'b0010111, 7'b1110011};
  logic [6:0] ops     [7] = '{LW, SW, RT, IT, BR, JAL, JALR};

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    op = '0; funct3 = '0; funct7_5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
    do_reset();
    instr("add",       RT, 3'b000, 1'b0, 1'b0, 0, 0);
    instr("sub",       RT, 3'b000, 1'b1, 1'b0, 0, 0);
    instr("addi_f7",   IT, 3'b000, 1'b1, 1'b0, 0, 0);
    instr("lw_wait3",  LW, 3'b010, 1'b0, 1'b0, 0, 3);
    instr("sw_wait2",  SW, 3'b010, 1'b0, 1'b0, 0, 2);
    instr("beq_z1",    BR, 3'b000, 1'b0, 1'b1, 0, 0);
    instr("bne_z1",    BR, 3'b001, 1'b0, 1'b1, 0, 0);
    instr("br_f3_100", BR, 3'b100, 1'b0, 1'b0, 0, 0);
    instr("jal",       JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    instr("jalr",      JALR, 3'b000, 1'b0, 1'b0, 0, 0);
    instr("illegal",   7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
    instr("fetch_to",  RT, 3'b000, 1'b0, 1'b0, TO + 1, 0);
    instr("fetch_lim", RT, 3'b110, 1'b0, 1'b0, TO, 0);
    instr("rd_lim",    LW, 3'b010, 1'b0, 1'b0, 0, TO);
    instr("wr_to",     SW, 3'b010, 1'b0, 1'b0, 0, TO + 1);

    // Async reset in the middle of a stalled store.
    op = SW; funct3 = 3'b010; funct7_5 = 1'b0; Zero = 1'b0;
    build(SW, 3'b010, 1'b0, 1'b0, 0, 3);
    run(5, "sw_pre_rst");
    mem_ready = 1'b0;
    #2 check("mw_hold", obs, q[5].o);
    rst_n = 1'b0;
    #1 check("async_rst", obs, '0);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      logic [6:0] o;
      int k = int'($urandom_range(0, 8));
      o = (k >= 7) ? ill_ops[$urandom_range(0, 3)] : ops[k];
      instr("rand", o, 3'($urandom), rb(), rb(), pick_wait(), pick_wait());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
